apb_image_loader: RTL and testbench
===================================

APB_IMAGE_LOADER -- requirements
Module: apb_image_loader

Interface
REQ-001 Parameter AMBA_WORD, default 24: APB data width in bits.
REQ-002 Parameter AMBA_ADDR_DEPTH, default 12: APB address width in bits.
REQ-003 Parameter PIX_WIDTH, default 8: pixel width in bits; AMBA_WORD SHALL be an integer multiple of it (PPW = AMBA_WORD/PIX_WIDTH).
REQ-004 Parameter NUM_PIXELS, default 12288: pixels per image; SHALL be a multiple of PPW (NWORDS = NUM_PIXELS/PPW).
REQ-005 clk  in  1  single system clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to load one image; sampled only in IDLE.
REQ-008 busy  out  1  high from the cycle after an accepted start until DONE is left.
REQ-009 done  out  1  one-cycle pulse after the final start-work write completes.
REQ-010 err  out  1  sticky; set on any PSLVERR, cleared by the next accepted start.
REQ-011 pix_valid / pix_ready / pix_data  in / out / in  1 / 1 / PIX_WIDTH  pixel stream; transfer when pix_valid and pix_ready are both high.
REQ-012 PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
REQ-013 PADDR  out  AMBA_ADDR_DEPTH+1  APB address.
REQ-014 PWDATA  out  AMBA_WORD  APB write data.
REQ-015 PREADY, PSLVERR  in  1 each  APB completer response.

Function
REQ-016 FSM states: IDLE, STOP_SETUP, STOP_ACCESS, LOAD, W_SETUP, W_ACCESS, GO_SETUP, GO_ACCESS, DONE.
REQ-017 IDLE -> STOP_SETUP when start is high; start in any other state is ignored.
REQ-018 STOP write: PADDR=0, PWDATA=0 (halt the recognizer before loading).
REQ-019 LOAD: pix_ready=1; one pixel accepted per handshake; pix_ready=0 in every other state.
REQ-020 Packing: the first pixel of a word goes to the MSBs. A word is {p0,p1,...,p(PPW-1)}.
REQ-021 After the PPW-th pixel of a word is accepted, the next state is W_SETUP.
REQ-022 The word k write (k = 0..NWORDS-1) SHALL use PADDR = k+1.
REQ-023 After W_ACCESS completes, go to LOAD if words remain, else to GO_SETUP.
REQ-024 GO write: PADDR=0, PWDATA=1 (start_work), then DONE (done=1 for one cycle), then IDLE.
REQ-025 APB timing: *_SETUP drives PSEL=1, PWRITE=1, PENABLE=0 for exactly one cycle.
REQ-026 *_ACCESS drives PENABLE=1 and holds PADDR/PWDATA stable until PREADY=1; the transfer completes on that edge.
REQ-027 PSEL and PENABLE are 0 in IDLE, LOAD and DONE. PADDR and PWDATA are held at their last value there.
REQ-028 PSLVERR is sampled only on a completing edge; if high, err is set; the sequence continues.
REQ-029 Minimum latency with pix_valid constantly high and PREADY=1: start accepted to done = 4 + NWORDS*(PPW+2) cycles.
REQ-030 Word counter width = clog2(NWORDS+1). Pixel counter wraps to 0 after each full word; no overflow past NWORDS.
REQ-031 Pixels presented while not in LOAD are not consumed and not lost (pix_ready low).

Reset
REQ-032 While rst=0: state=IDLE and counters=0. Outputs: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, busy=0, done=0, err=0, pix_ready=0.
REQ-033 Reset mid-transfer drops PSEL/PENABLE asynchronously; the partial image is discarded; the next start restarts from STOP.

Structure
REQ-034 A shared package holds: the state enum, the register address constants (START_WORK_ADDR=0, IMAGE_BASE_ADDR=1) and the start-work values (STOP=0, GO=1).
REQ-035 One sub-module, apb_write_master, SHALL own the SETUP/ACCESS/PREADY sequencing and signal completion to the top FSM.

Verification (NUM_PIXELS=6, AMBA_WORD=24, PIX_WIDTH=8 unless stated)
REQ-036 Pixel stream 0x11..0x66, PREADY=1 -> writes observed in order:
- (0,0x000000)
- (1,0x112233)
- (2,0x445566)
- (0,0x000001)
Then done at cycle 14 after start.
REQ-037 Same stream, PREADY low for 3 cycles on the addr-1 write -> PADDR/PWDATA stable throughout; done at cycle 17.
REQ-038 pix_valid toggling 1,0,1,0 -> only handshaken pixels packed; write data is unchanged from REQ-036.
REQ-039 PSLVERR=1 on the addr-2 write -> err=1 and stays 1; the GO write is still issued; the next start clears err.
REQ-040 rst asserted during W_ACCESS of word 1 -> PSEL=0 immediately. After release, a new start yields the full REQ-036 sequence.
REQ-041 start pulsed while busy -> ignored: exactly one done and four writes.

Source files
------------

// File: rtl/apb_image_loader_pkg.sv
// Shared types and register map for the APB image loader.
package apb_image_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    STOP_SETUP,
    STOP_ACCESS,
    LOAD,
    W_SETUP,
    W_ACCESS,
    GO_SETUP,
    GO_ACCESS,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } phase_t;

  localparam int START_WORK_ADDR = 0;
  localparam int IMAGE_BASE_ADDR = 1;

  localparam int STOP = 0;
  localparam int GO   = 1;

endpackage

// File: rtl/apb_image_loader_if.sv
// APB bus between the image loader (requester) and the recognizer (completer).
interface apb_image_loader_if #(
  parameter int AMBA_WORD       = 24,
  parameter int AMBA_ADDR_DEPTH = 12
);
  logic                     PSEL;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [AMBA_ADDR_DEPTH:0] PADDR;
  logic [AMBA_WORD-1:0]     PWDATA;
  logic                     PREADY;
  logic                     PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_write_master.sv
// Single-write APB requester: a req pulse launches SETUP then ACCESS until PREADY.
module apb_write_master
  import apb_image_loader_pkg::*;
#(
  parameter int AMBA_WORD       = 24,
  parameter int AMBA_ADDR_DEPTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [AMBA_ADDR_DEPTH:0] req_addr,
  input  logic [AMBA_WORD-1:0]     req_data,
  output logic                     complete,
  output logic                     slverr,
  apb_image_loader_if.master       apb
);

  phase_t                   phase_reg, phase_next;
  logic [AMBA_ADDR_DEPTH:0] addr_reg;
  logic [AMBA_WORD-1:0]     data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_reg <= PH_IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      phase_reg <= phase_next;
      if (req) begin
        addr_reg <= req_addr;
        data_reg <= req_data;
      end
    end
  end

  // A new request may arrive on the very edge that completes the current one.
  always_comb begin
    phase_next = phase_reg;
    complete   = 1'b0;
    case (phase_reg)
      PH_IDLE:   if (req) phase_next = PH_SETUP;
      PH_SETUP:  phase_next = PH_ACCESS;
      PH_ACCESS: begin
        if (apb.PREADY) begin
          complete   = 1'b1;
          phase_next = req ? PH_SETUP : PH_IDLE;
        end
      end
      default:   phase_next = PH_IDLE;
    endcase
  end

  assign apb.PSEL    = (phase_reg != PH_IDLE);
  assign apb.PENABLE = (phase_reg == PH_ACCESS);
  assign apb.PWRITE  = (phase_reg != PH_IDLE);
  assign apb.PADDR   = addr_reg;
  assign apb.PWDATA  = data_reg;
  assign slverr      = complete & apb.PSLVERR;

endmodule

// File: rtl/apb_image_loader.sv
// Streams pixels in, packs them MSB-first into APB words and writes one image to the recognizer.
module apb_image_loader
  import apb_image_loader_pkg::*;
#(
  parameter int AMBA_WORD       = 24,
  parameter int AMBA_ADDR_DEPTH = 12,
  parameter int PIX_WIDTH       = 8,
  parameter int NUM_PIXELS      = 12288
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIX_WIDTH-1:0] pix_data,
  apb_image_loader_if.master   apb
);

  localparam int PPW        = AMBA_WORD / PIX_WIDTH;
  localparam int NWORDS     = NUM_PIXELS / PPW;
  localparam int WORD_CNT_W = $clog2(NWORDS + 1);
  localparam int PIX_CNT_W  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PART_W     = (PPW > 1) ? AMBA_WORD - PIX_WIDTH : 1;
  localparam int ADDR_W     = AMBA_ADDR_DEPTH + 1;

  state_t                state_reg, state_next;
  logic [PIX_CNT_W-1:0]  pix_cnt_reg, pix_cnt_next;
  logic [WORD_CNT_W-1:0] word_cnt_reg, word_cnt_next;
  logic [PART_W-1:0]     partial_reg, partial_next;
  logic                  err_reg, err_next;
  logic [AMBA_WORD-1:0]  word_shift;

  logic                  req, complete, slverr;
  logic [ADDR_W-1:0]     req_addr;
  logic [AMBA_WORD-1:0]  req_data;

  // Earlier pixels shift toward the MSBs as each new pixel enters at the bottom.
  generate
    if (PPW == 1) begin : g_single
      assign word_shift = pix_data;
    end else begin : g_multi
      assign word_shift = {partial_reg, pix_data};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      pix_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      partial_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pix_cnt_reg  <= pix_cnt_next;
      word_cnt_reg <= word_cnt_next;
      partial_reg  <= partial_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pix_cnt_next  = pix_cnt_reg;
    word_cnt_next = word_cnt_reg;
    partial_next  = partial_reg;
    err_next      = err_reg;
    req           = 1'b0;
    req_addr      = '0;
    req_data      = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = STOP_SETUP;
          req           = 1'b1;
          req_addr      = ADDR_W'(START_WORK_ADDR);
          req_data      = AMBA_WORD'(STOP);
          err_next      = 1'b0;
          pix_cnt_next  = '0;
          word_cnt_next = '0;
        end
      end
      STOP_SETUP:  state_next = STOP_ACCESS;
      STOP_ACCESS: if (complete) state_next = LOAD;
      LOAD: begin
        if (pix_valid) begin
          partial_next = word_shift[PART_W-1:0];
          if (pix_cnt_reg == PIX_CNT_W'(PPW - 1)) begin
            pix_cnt_next = '0;
            state_next   = W_SETUP;
            req          = 1'b1;
            req_addr     = ADDR_W'(IMAGE_BASE_ADDR) + ADDR_W'(word_cnt_reg);
            req_data     = word_shift;
          end else begin
            pix_cnt_next = pix_cnt_reg + PIX_CNT_W'(1);
          end
        end
      end
      W_SETUP: state_next = W_ACCESS;
      W_ACCESS: begin
        if (complete) begin
          if (word_cnt_reg == WORD_CNT_W'(NWORDS - 1)) begin
            word_cnt_next = '0;
            state_next    = GO_SETUP;
            req           = 1'b1;
            req_addr      = ADDR_W'(START_WORK_ADDR);
            req_data      = AMBA_WORD'(GO);
          end else begin
            word_cnt_next = word_cnt_reg + WORD_CNT_W'(1);
            state_next    = LOAD;
          end
        end
      end
      GO_SETUP:  state_next = GO_ACCESS;
      GO_ACCESS: if (complete) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (slverr) err_next = 1'b1;
  end

  assign pix_ready = (state_reg == LOAD);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign err       = err_reg;

  apb_write_master #(
    .AMBA_WORD      (AMBA_WORD),
    .AMBA_ADDR_DEPTH(AMBA_ADDR_DEPTH)
  ) u_wr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_addr(req_addr),
    .req_data(req_data),
    .complete(complete),
    .slverr  (slverr),
    .apb     (apb)
  );

endmodule

// File: tb/tb_apb_image_loader.sv
// Directed and randomized image loads checked against a word-list model of the expected APB writes.
module tb_apb_image_loader;

  localparam int AW  = 24;
  localparam int AD  = 12;
  localparam int PW  = 8;
  localparam int NP  = 6;
  localparam int PPW = AW / PW;
  localparam int NW  = NP / PPW;
  localparam int BASE_LAT = 4 + NW * (PPW + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [PW-1:0] pix_data = '0;

  apb_image_loader_if #(.AMBA_WORD(AW), .AMBA_ADDR_DEPTH(AD)) apb ();

  apb_image_loader #(
    .AMBA_WORD      (AW),
    .AMBA_ADDR_DEPTH(AD),
    .PIX_WIDTH      (PW),
    .NUM_PIXELS     (NP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data (pix_data),
    .apb      (apb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // run results
  int            lat, dones, stalls, unstable;
  bit            aborted, busy_start, err_start, busy_after, err_end;
  int            wa_q[$];
  logic [AW-1:0] wd_q[$];
  logic [PW-1:0] pix_q[$];
  logic [PW-1:0] img[NP];
  int            exp_a[$];
  logic [AW-1:0] exp_d[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected write list: stop, one word per PPW pixels (first pixel in MSBs), go.
  task automatic build_model();
    logic [AW-1:0] d;
    exp_a.delete();
    exp_d.delete();
    exp_a.push_back(0);
    exp_d.push_back('0);
    for (int w = 0; w < NW; w++) begin
      d = '0;
      for (int j = 0; j < PPW; j++) d = (d << PW) | AW'(img[w * PPW + j]);
      exp_a.push_back(w + 1);
      exp_d.push_back(d);
    end
    exp_a.push_back(0);
    exp_d.push_back(AW'(1));
  endtask

  task automatic run_image(input int vmode, input int stall_addr, input int stall_n,
                           input bit rstall, input int err_addr, input bit rst_mid,
                           input bit extra_start);
    int            cyc, budget;
    bit            tog;
    logic [AD:0]   s_addr;
    logic [AW-1:0] s_data;
    wa_q.delete();
    wd_q.delete();
    pix_q.delete();
    foreach (img[i]) pix_q.push_back(img[i]);
    lat = -1; dones = 0; stalls = 0; unstable = 0; aborted = 0;
    busy_after = 1'b1; busy_start = 1'b0; err_start = 1'b1;
    budget = 0; tog = 1'b1; s_addr = '0; s_data = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (cyc < 300) begin
      start = (extra_start && (cyc == 5 || cyc == 9));
      if (apb.PSEL && !apb.PENABLE) begin
        budget = (int'(apb.PADDR) == stall_addr) ? stall_n
               : (rstall ? int'($urandom_range(0, 2)) : 0);
        s_addr = apb.PADDR;
        s_data = apb.PWDATA;
      end
      if (apb.PSEL && apb.PENABLE) begin
        if (apb.PADDR !== s_addr || apb.PWDATA !== s_data) unstable++;
        apb.PREADY  = (budget == 0);
        apb.PSLVERR = (int'(apb.PADDR) == err_addr);
        if (budget > 0) begin
          budget--;
          stalls++;
        end
      end else begin
        apb.PREADY  = 1'b1;
        apb.PSLVERR = 1'b0;
      end
      case (vmode)
        0: pix_valid = (pix_q.size() > 0);
        1: begin
          pix_valid = tog && (pix_q.size() > 0);
          tog = !tog;
        end
        default: pix_valid = ($urandom_range(0, 1) == 1) && (pix_q.size() > 0);
      endcase
      pix_data = pix_valid ? pix_q[0] : PW'($urandom);
      #1;
      if (cyc == 0) begin
        busy_start = busy;
        err_start  = err;
      end
      if (pix_valid && pix_ready) void'(pix_q.pop_front());
      if (apb.PSEL && apb.PENABLE && apb.PREADY) begin
        wa_q.push_back(int'(apb.PADDR));
        wd_q.push_back(apb.PWDATA);
      end
      if (rst_mid && apb.PSEL && apb.PENABLE && int'(apb.PADDR) == 2) begin
        rst = 1'b0;
        #1;
        check("rst_mid_psel", apb.PSEL, 0);
        check("rst_mid_penable", apb.PENABLE, 0);
        check("rst_mid_busy", busy, 0);
        aborted = 1'b1;
        break;
      end
      if (done) begin
        dones++;
        if (lat < 0) lat = cyc;
      end
      if (lat >= 0 && cyc == lat + 1) busy_after = busy;
      if (lat >= 0 && cyc >= lat + 4) break;
      @(negedge clk);
      cyc++;
    end
    start       = 1'b0;
    pix_valid   = 1'b0;
    apb.PREADY  = 1'b1;
    apb.PSLVERR = 1'b0;
    err_end     = err;
    if (!aborted) check("done_within_budget", (lat >= 0), 1);
  endtask

  task automatic verify(input string tag, input int exp_lat, input bit exp_err);
    check({tag, "_nwrites"}, wa_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wa_q[i], exp_a[i]);
      check($sformatf("%s_data%0d", tag, i), wd_q[i], exp_d[i]);
    end
    check({tag, "_dones"}, dones, 1);
    check({tag, "_busy_start"}, busy_start, 1);
    check({tag, "_err_cleared"}, err_start, 0);
    check({tag, "_busy_after"}, busy_after, 0);
    check({tag, "_err_end"}, err_end, exp_err);
    check({tag, "_stable"}, unstable, 0);
    if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
    $display("%s: %0d writes, done at cycle %0d, err=%0b", tag, wa_q.size(), lat, err_end);
  endtask

  initial begin
    apb.PREADY  = 1'b1;
    apb.PSLVERR = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_psel", apb.PSEL, 0);
    check("reset_penable", apb.PENABLE, 0);
    check("reset_pwrite", apb.PWRITE, 0);
    check("reset_paddr", apb.PADDR, 0);
    check("reset_pwdata", apb.PWDATA, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_pix_ready", pix_ready, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NP; i++) img[i] = PW'((i + 1) * 17);
    build_model();

    run_image(0, -1, 0, 1'b0, -1, 1'b0, 1'b0);
    verify("basic", BASE_LAT, 1'b0);

    run_image(0, 1, 3, 1'b0, -1, 1'b0, 1'b0);
    verify("stall3", BASE_LAT + 3, 1'b0);

    run_image(1, -1, 0, 1'b0, -1, 1'b0, 1'b0);
    verify("toggle", -1, 1'b0);

    run_image(0, -1, 0, 1'b0, 2, 1'b0, 1'b0);
    verify("slverr", BASE_LAT, 1'b1);

    run_image(0, -1, 0, 1'b0, -1, 1'b0, 1'b0);
    verify("after_err", BASE_LAT, 1'b0);

    run_image(0, -1, 0, 1'b0, -1, 1'b1, 1'b0);
    check("rst_mid_reached", aborted, 1);
    @(negedge clk);
    check("rst_hold_bus", {apb.PSEL, apb.PENABLE, apb.PWRITE, busy, done, pix_ready}, 0);
    check("rst_hold_paddr", apb.PADDR, 0);
    rst = 1'b1;
    @(negedge clk);
    run_image(0, -1, 0, 1'b0, -1, 1'b0, 1'b0);
    verify("after_rst", BASE_LAT, 1'b0);

    run_image(0, -1, 0, 1'b0, -1, 1'b0, 1'b1);
    verify("start_busy", BASE_LAT, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NP; i++) img[i] = PW'($urandom);
      build_model();
      run_image((r < 3) ? 0 : 2, -1, 0, 1'b1, -1, 1'b0, 1'b0);
      verify($sformatf("rand%0d", r), (r < 3) ? BASE_LAT + stalls : -1, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
